// File: rtl/i2s_rx_frame_fifo_if.sv
// Stream interface carrying captured stereo pairs from the frame FIFO to the
// DSP/DMA consumer. The left sample occupies the upper half of M_TDATA.
interface i2s_rx_frame_fifo_if #(
   parameter int DATA_WIDTH = 16
);
   logic [2*DATA_WIDTH-1:0] M_TDATA;
   logic                    M_TVALID;
   logic                    M_TREADY;

   modport master (output M_TDATA, output M_TVALID, input M_TREADY);
   modport slave  (input M_TDATA, input M_TVALID, output M_TREADY);
endinterface

// File: rtl/i2s_rx_frame_fifo.sv
// I2S receive frame capture: detects the LRCLK falling edge (start of a new
// stereo frame), waits CAP_DLY cycles, then stores the completed {left,right}
// pair in a small first-word-fall-through FIFO drained over a valid/ready
// stream. Pairs that cannot be stored are dropped, flagged and counted.
module i2s_rx_frame_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int CAP_DLY    = 2
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic                     EN_I,
   input  logic                     LRCLK_I,
   input  logic [DATA_WIDTH-1:0]    D_L_I,
   input  logic [DATA_WIDTH-1:0]    D_R_I,
   i2s_rx_frame_fifo_if.master      m_axis,
   output logic [$clog2(DEPTH):0]   LEVEL_O,
   output logic                     OVF_O,
   input  logic                     CLR_OVF_I,
   output logic [7:0]               DROP_CNT_O
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [3:0] DLY_LOAD = (CAP_DLY == 0) ? 4'd0 : 4'(CAP_DLY - 1);

   typedef enum logic {IDLE, WAIT} cap_state_t;

   cap_state_t              state_q, state_d;
   logic [3:0]              dly_q, dly_d;
   logic                    lrclk_q;
   logic                    fall;
   logic                    cap;

   logic [2*DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic                    ovf_q, ovf_d;
   logic [7:0]              drop_q, drop_d;
   logic                    pop, push, drop;

   assign fall = lrclk_q & ~LRCLK_I;

   // Capture FSM: schedule a capture CAP_DLY cycles after each falling edge.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      cap     = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall && EN_I) begin
               if (CAP_DLY == 0) begin
                  cap = 1'b1;
               end else begin
                  dly_d   = DLY_LOAD;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!EN_I) begin
               state_d = IDLE;
            end else if (fall) begin
               // A new frame started before the old capture fired: restart.
               dly_d = DLY_LOAD;
            end else if (dly_q == 4'd0) begin
               cap     = 1'b1;
               state_d = IDLE;
            end else begin
               dly_d = dly_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO control and overflow bookkeeping.
   always_comb begin
      pop      = (level_q != '0) & m_axis.M_TREADY;
      push     = cap & ((level_q < FULL_LVL) | pop);
      drop     = cap & ~push;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (drop) begin
         // A drop coincident with a clear counts as the first drop after it.
         ovf_d  = 1'b1;
         drop_d = CLR_OVF_I ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
      end else if (CLR_OVF_I) begin
         ovf_d  = 1'b0;
         drop_d = 8'd0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q  <= IDLE;
         dly_q    <= 4'd0;
         lrclk_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         lrclk_q  <= LRCLK_I;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Pair storage; contents need no reset since level gates visibility.
   always_ff @(posedge CLK_I) begin
      if (push) begin
         mem[wr_ptr_q] <= {D_L_I, D_R_I};
      end
   end

   assign m_axis.M_TDATA  = mem[rd_ptr_q];
   assign m_axis.M_TVALID = (level_q != '0);
   assign LEVEL_O         = level_q;
   assign OVF_O           = ovf_q;
   assign DROP_CNT_O      = drop_q;

endmodule
